// File: rtl/dither_gen_v1_core_if.sv
// Bus bundle for the dither generator: trigger/configuration/sample inputs and result/state outputs.
// DITHER_GEN_DEBUG_PORTS_EN adds the accumulator and sum observation ports.
interface dither_gen_v1_core_if;
    logic               i_trig;
    logic        [2:0]  i_avg_sel;
    logic        [31:0] i_wait_cnt;
    logic signed [31:0] i_data;
    logic signed [31:0] o_data;
    logic signed [31:0] o_dither_out;
    logic        [3:0]  o_cstate;
    logic        [3:0]  o_nstate;
`ifdef DITHER_GEN_DEBUG_PORTS_EN
    logic signed [31:0] o_reg_data_H;
    logic signed [31:0] o_reg_data_L;
    logic signed [31:0] o_reg_sum;

    modport slave (
        input  i_trig, i_avg_sel, i_wait_cnt, i_data,
        output o_data, o_dither_out, o_cstate, o_nstate,
        output o_reg_data_H, o_reg_data_L, o_reg_sum
    );
    modport master (
        output i_trig, i_avg_sel, i_wait_cnt, i_data,
        input  o_data, o_dither_out, o_cstate, o_nstate,
        input  o_reg_data_H, o_reg_data_L, o_reg_sum
    );
`else
    modport slave (
        input  i_trig, i_avg_sel, i_wait_cnt, i_data,
        output o_data, o_dither_out, o_cstate, o_nstate
    );
    modport master (
        output i_trig, i_avg_sel, i_wait_cnt, i_data,
        input  o_data, o_dither_out, o_cstate, o_nstate
    );
`endif
endinterface

// File: rtl/dither_gen_v1_core.sv
// Dither generator: alternates +1/-1 dither, averages the demodulated samples of each half and outputs (H - L) >>> avg_sel.
// Optional macro DITHER_GEN_DEBUG_PORTS_EN exposes the H/L accumulators and the last H-L sum.
module dither_gen_v1_core (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dither_gen_v1_core_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_DITHER_H = 4'd1,
        ST_WAIT_H   = 4'd2,
        ST_ACQ_H    = 4'd3,
        ST_DITHER_L = 4'd4,
        ST_WAIT_L   = 4'd5,
        ST_ACQ_L    = 4'd6,
        ST_OUT_GEN  = 4'd7
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] dither_q, dither_d;
    logic        [2:0]  avg_sel_q, avg_sel_d;
    logic        [31:0] wait_lat_q, wait_lat_d;
    logic        [31:0] wait_cnt_q, wait_cnt_d;
    logic        [7:0]  smp_cnt_q, smp_cnt_d;
    logic signed [31:0] acc_h_q, acc_h_d;
    logic signed [31:0] acc_l_q, acc_l_d;
    logic signed [31:0] data_q, data_d;
    logic signed [31:0] sum_c;
    logic        [7:0]  smp_last;

    assign smp_last = (8'd1 << avg_sel_q) - 8'd1;

    always_comb begin
        state_d    = state_q;
        dither_d   = dither_q;
        avg_sel_d  = avg_sel_q;
        wait_lat_d = wait_lat_q;
        wait_cnt_d = wait_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        acc_h_d    = acc_h_q;
        acc_l_d    = acc_l_q;
        data_d     = data_q;
        sum_c      = acc_h_q - acc_l_q;

        case (state_q)
            ST_RST: state_d = ST_DITHER_H;

            ST_DITHER_H, ST_DITHER_L: begin
                if (bus.i_trig) begin
                    avg_sel_d  = bus.i_avg_sel;
                    wait_lat_d = bus.i_wait_cnt;
                    wait_cnt_d = 32'd0;
                    smp_cnt_d  = 8'd0;
                    if (state_q == ST_DITHER_H) begin
                        dither_d = 32'sd1;
                        acc_h_d  = 32'sd0;
                        state_d  = ST_WAIT_H;
                    end else begin
                        dither_d = -32'sd1;
                        acc_l_d  = 32'sd0;
                        state_d  = ST_WAIT_L;
                    end
                end
            end

            // Counter runs 0..N inclusive, so the wait spans N+1 cycles.
            ST_WAIT_H, ST_WAIT_L: begin
                if (wait_cnt_q == wait_lat_q) begin
                    state_d = (state_q == ST_WAIT_H) ? ST_ACQ_H : ST_ACQ_L;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end

            ST_ACQ_H: begin
                acc_h_d = acc_h_q + bus.i_data;
                if (smp_cnt_q == smp_last) begin
                    state_d = ST_DITHER_L;
                end else begin
                    smp_cnt_d = smp_cnt_q + 8'd1;
                end
            end

            ST_ACQ_L: begin
                acc_l_d = acc_l_q + bus.i_data;
                if (smp_cnt_q == smp_last) begin
                    state_d = ST_OUT_GEN;
                end else begin
                    smp_cnt_d = smp_cnt_q + 8'd1;
                end
            end

            ST_OUT_GEN: begin
                data_d  = sum_c >>> avg_sel_q;
                state_d = ST_DITHER_H;
            end

            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RST;
            dither_q   <= 32'sd0;
            avg_sel_q  <= 3'd0;
            wait_lat_q <= 32'd0;
            wait_cnt_q <= 32'd0;
            smp_cnt_q  <= 8'd0;
            acc_h_q    <= 32'sd0;
            acc_l_q    <= 32'sd0;
            data_q     <= 32'sd0;
        end else begin
            state_q    <= state_d;
            dither_q   <= dither_d;
            avg_sel_q  <= avg_sel_d;
            wait_lat_q <= wait_lat_d;
            wait_cnt_q <= wait_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            acc_h_q    <= acc_h_d;
            acc_l_q    <= acc_l_d;
            data_q     <= data_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_dither_out = dither_q;
    assign bus.o_cstate     = state_q;
    assign bus.o_nstate     = state_d;

`ifdef DITHER_GEN_DEBUG_PORTS_EN
    logic signed [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_OUT_GEN) begin
            sum_d = sum_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q <= 32'sd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.o_reg_data_H = acc_h_q;
    assign bus.o_reg_data_L = acc_l_q;
    assign bus.o_reg_sum    = sum_q;
`else
    // Without debug ports the H-L sum exists only transiently inside OUT_GEN.
`endif
endmodule

// File: tb/tb_dither_gen_v1_core.sv
// Directed testbench for dither_gen_v1_core: loop timing, extra triggers, minimum config, overflow and mid-cycle reset.
module tb_dither_gen_v1_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [31:0] h_val = 32'sd0;
    logic signed [31:0] l_val = 32'sd0;
    int n_checks = 0;
    int n_errors = 0;
    int run_len;

    dither_gen_v1_core_if bus();

    dither_gen_v1_core dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Sample stream follows the dither level: H value under +1, L value under -1.
    assign bus.i_data = (bus.o_dither_out == 32'sd1)  ? h_val :
                        (bus.o_dither_out == -32'sd1) ? l_val : 32'sd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
        end else begin
            $display("ok   %s: %0d", tag, $signed(obs));
        end
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        bus.i_trig = 1'b1;
        @(negedge clk);
        bus.i_trig = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] code);
        int n = 0;
        while (bus.o_cstate !== code && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {28'd0, bus.o_cstate}, {28'd0, code});
    endtask

    task automatic count_run(input logic [3:0] code, output int n);
        n = 0;
        while (bus.o_cstate === code && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_cfg(input logic [2:0] avg, input logic [31:0] wcnt,
                           input logic signed [31:0] h, input logic signed [31:0] l);
        bus.i_avg_sel  = avg;
        bus.i_wait_cnt = wcnt;
        h_val = h;
        l_val = l;
    endtask

    initial begin
        bus.i_trig = 1'b0;
        set_cfg(3'd4, 32'd9, 32'sd1000, -32'sd2100);
        repeat (3) @(negedge clk);
        check_val("rst_cstate", {28'd0, bus.o_cstate}, 32'd0);
        check_val("rst_dither", bus.o_dither_out, 32'd0);
        check_val("rst_data", bus.o_data, 32'd0);
        check_val("rst_nstate", {28'd0, bus.o_nstate}, 32'd1);
`ifdef DITHER_GEN_DEBUG_PORTS_EN
        check_val("rst_sum", bus.o_reg_sum, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_val("first_dither_h", {28'd0, bus.o_cstate}, 32'd1);

        // Loop 1: basic timing and result
        @(negedge clk);
        bus.i_trig = 1'b1;
        #1 check_val("nstate_on_trig", {28'd0, bus.o_nstate}, 32'd2);
        @(negedge clk);
        bus.i_trig = 1'b0;
        check_val("dither_h", bus.o_dither_out, 32'd1);
        count_run(4'd2, run_len);
        check_val("wait_h_len", run_len, 32'd10);
        count_run(4'd3, run_len);
        check_val("acq_h_len", run_len, 32'd16);
        check_val("to_dither_l", {28'd0, bus.o_cstate}, 32'd4);
`ifdef DITHER_GEN_DEBUG_PORTS_EN
        check_val("acc_h", bus.o_reg_data_H, 32'd16000);
`endif
        repeat (20) @(negedge clk);
        check_val("dither_hold_h", bus.o_dither_out, 32'd1);
        pulse_trig();
        check_val("dither_l", bus.o_dither_out, 32'hFFFF_FFFF);
        count_run(4'd5, run_len);
        check_val("wait_l_len", run_len, 32'd10);
        count_run(4'd6, run_len);
        check_val("acq_l_len", run_len, 32'd16);
        check_val("out_gen", {28'd0, bus.o_cstate}, 32'd7);
        check_val("data_before_out", bus.o_data, 32'd0);
        @(negedge clk);
        check_val("loop1_data", bus.o_data, 32'd3100);
        check_val("back_dither_h", {28'd0, bus.o_cstate}, 32'd1);
`ifdef DITHER_GEN_DEBUG_PORTS_EN
        check_val("acc_l", bus.o_reg_data_L, -32'sd33600);
        check_val("sum", bus.o_reg_sum, 32'd49600);
`endif

        // Loop 2: extra triggers in WAIT_H and ACQ_H are ignored
        pulse_trig();
        repeat (3) @(negedge clk);
        pulse_trig();
        check_val("xtrig_wait_state", {28'd0, bus.o_cstate}, 32'd2);
        check_val("xtrig_wait_dither", bus.o_dither_out, 32'd1);
        wait_state("reach_acq_h", 4'd3);
        pulse_trig();
        check_val("xtrig_acq_state", {28'd0, bus.o_cstate}, 32'd3);
        check_val("xtrig_acq_dither", bus.o_dither_out, 32'd1);
        wait_state("reach_dither_l", 4'd4);
        repeat (5) @(negedge clk);
        check_val("dither_l_holds", {28'd0, bus.o_cstate}, 32'd4);
        check_val("data_holds", bus.o_data, 32'd3100);
        pulse_trig();
        wait_state("loop2_done", 4'd1);
        check_val("loop2_data", bus.o_data, 32'd3100);

        // Minimum configuration
        set_cfg(3'd0, 32'd0, 32'sd5, -32'sd5);
        pulse_trig();
        count_run(4'd2, run_len);
        check_val("min_wait_len", run_len, 32'd1);
        count_run(4'd3, run_len);
        check_val("min_acq_len", run_len, 32'd1);
        pulse_trig();
        wait_state("min_done", 4'd1);
        check_val("min_data", bus.o_data, 32'd10);

        // Overflow wrap: 2 x 0x7FFFFFFF = 0xFFFFFFFE, >>> 1 = -1
        set_cfg(3'd1, 32'd0, 32'sh7FFF_FFFF, 32'sd0);
        pulse_trig();
        wait_state("ovf_dither_l", 4'd4);
`ifdef DITHER_GEN_DEBUG_PORTS_EN
        check_val("ovf_acc_h", bus.o_reg_data_H, 32'hFFFF_FFFE);
`endif
        pulse_trig();
        wait_state("ovf_done", 4'd1);
        check_val("ovf_data", bus.o_data, 32'hFFFF_FFFF);

        // Mid-cycle reset during ACQ_L
        set_cfg(3'd4, 32'd9, 32'sd1000, -32'sd2100);
        pulse_trig();
        wait_state("mr_dither_l", 4'd4);
        pulse_trig();
        wait_state("mr_acq_l", 4'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mr_cstate", {28'd0, bus.o_cstate}, 32'd0);
        check_val("mr_dither", bus.o_dither_out, 32'd0);
        check_val("mr_data", bus.o_data, 32'd0);
        @(negedge clk);
        check_val("mr_dither_h", {28'd0, bus.o_cstate}, 32'd1);
        repeat (10) @(negedge clk);
        check_val("mr_idle", {28'd0, bus.o_cstate}, 32'd1);
        check_val("mr_idle_data", bus.o_data, 32'd0);
        pulse_trig();
        wait_state("mr_dither_l2", 4'd4);
        pulse_trig();
        wait_state("mr_done", 4'd1);
        check_val("mr_restart_data", bus.o_data, 32'd3100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dither_gen_v1_core.md
DITHER_GEN_V1_CORE -- requirements
Module: dither_gen_v1

Interface
REQ-001 SHALL have one clock domain and a synchronous, active-high reset.
REQ-002 SHALL provide `i_clk`, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-003 SHALL provide `i_rst`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL provide `i_trig`, input, 1 bit: single-cycle pulse that starts each dither half-period.
REQ-005 SHALL provide `i_avg_sel`, input, 3 bits: number of samples averaged per half-period, equal to 2^i_avg_sel (1..128).
REQ-006 SHALL provide `i_wait_cnt`, input, 32 bits: settling wait length in clock cycles.
REQ-007 SHALL provide `i_data`, input, 32 bits, signed: demodulated sample stream.
REQ-008 SHALL provide `o_data`, output, 32 bits, signed: averaged H-minus-L result.
REQ-009 SHALL provide `o_dither_out`, output, 32 bits, signed: dither level, one of +1, -1 or 0.
REQ-010 SHALL provide `o_cstate`, output, 4 bits: current state code.
REQ-011 SHALL provide `o_nstate`, output, 4 bits: combinational next-state code.

Function
REQ-012 SHALL use these state encodings: RST=0, DITHER_H=1, WAIT_H=2, ACQ_H=3, DITHER_L=4, WAIT_L=5, ACQ_L=6, OUT_GEN=7; codes 8..15 are unused and SHALL recover to RST on the next cycle.
REQ-013 RST SHALL go to DITHER_H unconditionally on the next cycle.
REQ-014 DITHER_H SHALL hold until i_trig=1; on the trigger cycle it SHALL:
- set o_dither_out=+1,
- latch i_avg_sel and i_wait_cnt,
- clear the H accumulator,
- clear the wait counter,
- go to WAIT_H.
REQ-015 WAIT_H SHALL last exactly latched_wait_cnt+1 cycles (the counter runs from 0 to N) and then go to ACQ_H; a value of 0 gives a 1-cycle wait.
REQ-016 ACQ_H SHALL add signed i_data into the H accumulator on each of 2^latched_avg_sel consecutive cycles, then go to DITHER_L.
REQ-017 DITHER_L, WAIT_L and ACQ_L SHALL behave like REQ-014 to REQ-016, with these differences:
- o_dither_out=-1,
- the L accumulator is used,
- i_avg_sel and i_wait_cnt are latched again on the DITHER_L trigger,
- ACQ_L exits to OUT_GEN.
REQ-018 OUT_GEN SHALL last 1 cycle: sum = H_acc - L_acc and o_data = sum arithmetically shifted right by latched_avg_sel; it then goes to DITHER_H.
REQ-019 o_dither_out SHALL hold its level from its trigger until the next opposite trigger.
REQ-020 o_data SHALL change only in OUT_GEN and hold otherwise.
REQ-021 i_trig SHALL be ignored in every state other than DITHER_H and DITHER_L, including a trigger during WAIT or ACQ.
REQ-022 All accumulation and subtraction SHALL be 32-bit two's complement with modulo-2^32 wrap and no saturation.
REQ-023 o_cstate SHALL be registered.
REQ-024 o_nstate SHALL be combinational from the current state and inputs.

Reset
REQ-025 When i_rst=1 at a rising edge, the block SHALL set:
- state=RST,
- o_data=0,
- o_dither_out=0,
- accumulators, wait counter, sample counter and latched configuration all 0.
REQ-026 Reset asserted mid-operation SHALL abort the cycle immediately with no OUT_GEN update.
REQ-027 After reset deassertion the first DITHER_H SHALL be reached 1 cycle later.

Configuration
REQ-028 With macro DITHER_GEN_DEBUG_PORTS_EN defined, the block SHALL add three 32-bit outputs:
- o_reg_data_H: H accumulator,
- o_reg_data_L: L accumulator,
- o_reg_sum: last H-L sum, updated in OUT_GEN.
All three SHALL reset to 0.
REQ-029 Without DITHER_GEN_DEBUG_PORTS_EN, these ports and the o_reg_sum register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Basic loop. Stimulus:
- avg_sel=4, wait_cnt=9, trig every 101 cycles,
- i_data registered from dither: +1 gives 1000, -1 gives -2100.
Required response:
- o_reg_data_H=16000, o_reg_data_L=-33600, o_reg_sum=49600,
- o_data=3100 after each OUT_GEN.
REQ-031 Timing: with wait_cnt=9 and avg_sel=4, o_cstate SHALL show DITHER_H (1 cycle after trig) -> WAIT_H for 10 cycles -> ACQ_H for 16 cycles -> DITHER_L.
REQ-032 Extra trigger: a trig pulse during WAIT_H or ACQ_H SHALL be ignored, with no state change and unchanged o_dither_out.
REQ-033 Minimum config: avg_sel=0, wait_cnt=0, constant i_data=5 in H and -5 in L; o_data SHALL equal 10.
REQ-034 Mid-cycle reset: asserting i_rst during ACQ_L SHALL give o_cstate=0, o_dither_out=0, o_data=0 the next cycle; the cycle SHALL restart on the next trig after DITHER_H.
REQ-035 Overflow: H samples of 0x7FFFFFFF with avg_sel=1 SHALL wrap modulo 2^32 without error.
